// File: rtl/timer_int_ctrl_pkg.sv
// Shared constants and state encoding for the machine-timer interrupt controller.
package timer_int_ctrl_pkg;

    localparam logic [63:0] MCAUSE_MTI = 64'h8000_0000_0000_0007;

    typedef enum logic [1:0] {
        INT_IDLE  = 2'd0,
        INT_ARMED = 2'd1,
        INT_REQ   = 2'd2,
        INT_TRAP  = 2'd3
    } int_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear loads 1 so the clearing cycle itself is counted.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = W'(1);
        end else if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/timer_int_ctrl.sv
// Turns the timer level interrupt into a precise trap request at a retire boundary,
// holds it until the pipeline acks, blocks re-entry until mret and reports latency.
module timer_int_ctrl
    import timer_int_ctrl_pkg::*;
#(
    parameter int LAT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             timer_int_i,
    input  logic             mstatus_mie_i,
    input  logic             mie_mtie_i,
    input  logic             commit_valid_i,
    input  logic [63:0]      commit_npc_i,
    input  logic             int_ack_i,
    input  logic             mret_i,
    output logic             mip_mtip_o,
    output logic             int_req_o,
    output logic [63:0]      int_epc_o,
    output logic [63:0]      int_cause_o,
    output logic [LAT_W-1:0] int_latency_o,
    output logic             int_lat_vld_o
);

    int_state_e       state_q, state_d;
    logic             pending;
    logic             cnt_clr, cnt_inc, capture, ack_fire;
    logic [LAT_W-1:0] cnt_q, lat_now;
    logic [LAT_W-1:0] lat_q;
    logic [63:0]      epc_q, cause_q;
    logic             req_q, mip_q, lat_vld_q;

    assign pending = timer_int_i & mstatus_mie_i & mie_mtie_i;

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        capture  = 1'b0;
        ack_fire = 1'b0;
        unique case (state_q)
            INT_IDLE: begin
                if (pending) begin
                    cnt_clr = 1'b1;
                    if (commit_valid_i) begin
                        capture = 1'b1;
                        state_d = INT_REQ;
                    end else begin
                        state_d = INT_ARMED;
                    end
                end
            end
            INT_ARMED: begin
                // A pending drop beats a simultaneous commit: the trap is cancelled.
                if (!pending) begin
                    state_d = INT_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                    if (commit_valid_i) begin
                        capture = 1'b1;
                        state_d = INT_REQ;
                    end
                end
            end
            INT_REQ: begin
                cnt_inc = 1'b1;
                if (int_ack_i) begin
                    ack_fire = 1'b1;
                    state_d  = INT_TRAP;
                end
            end
            INT_TRAP: begin
                if (mret_i) begin
                    state_d = INT_IDLE;
                end
            end
            default: state_d = INT_IDLE;
        endcase
    end

    sat_counter #(.W(LAT_W)) u_lat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .q_o   (cnt_q)
    );

    // Reported latency includes the ack cycle itself.
    assign lat_now = (&cnt_q) ? cnt_q : cnt_q + LAT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INT_IDLE;
            mip_q     <= 1'b0;
            req_q     <= 1'b0;
            lat_vld_q <= 1'b0;
            lat_q     <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            mip_q     <= timer_int_i;
            req_q     <= (state_d == INT_REQ);
            lat_vld_q <= ack_fire;
            if (ack_fire) begin
                lat_q <= lat_now;
            end
            if (capture) begin
                epc_q   <= commit_npc_i;
                cause_q <= MCAUSE_MTI;
            end
        end
    end

    assign mip_mtip_o    = mip_q;
    assign int_req_o     = req_q;
    assign int_epc_o     = epc_q;
    assign int_cause_o   = cause_q;
    assign int_latency_o = lat_q;
    assign int_lat_vld_o = lat_vld_q;

endmodule

// File: tb/tb_timer_int_ctrl.sv
// Directed scenarios plus randomized traffic, checked against a timestamp-based reference model.
module tb_timer_int_ctrl;

    localparam int          LAT_W   = 16;
    localparam longint      LAT_MAX = (64'd1 << LAT_W) - 1;
    localparam logic [63:0] MTI     = 64'h8000_0000_0000_0007;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             timer_int_i = 1'b0;
    logic             mstatus_mie_i = 1'b0;
    logic             mie_mtie_i = 1'b0;
    logic             commit_valid_i = 1'b0;
    logic [63:0]      commit_npc_i = '0;
    logic             int_ack_i = 1'b0;
    logic             mret_i = 1'b0;
    logic             mip_mtip_o;
    logic             int_req_o;
    logic [63:0]      int_epc_o;
    logic [63:0]      int_cause_o;
    logic [LAT_W-1:0] int_latency_o;
    logic             int_lat_vld_o;

    timer_int_ctrl #(.LAT_W(LAT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .timer_int_i    (timer_int_i),
        .mstatus_mie_i  (mstatus_mie_i),
        .mie_mtie_i     (mie_mtie_i),
        .commit_valid_i (commit_valid_i),
        .commit_npc_i   (commit_npc_i),
        .int_ack_i      (int_ack_i),
        .mret_i         (mret_i),
        .mip_mtip_o     (mip_mtip_o),
        .int_req_o      (int_req_o),
        .int_epc_o      (int_epc_o),
        .int_cause_o    (int_cause_o),
        .int_latency_o  (int_latency_o),
        .int_lat_vld_o  (int_lat_vld_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: tracks whether a trap is waiting/outstanding/being serviced and the
    // cycle index at which the wait began; latency is plain timestamp arithmetic.
    bit          m_wait, m_req, m_trap, m_vld, m_mip;
    longint      cyc = 0, arm_cyc = 0;
    logic [63:0] m_epc, m_cause, m_lat;

    task automatic model_reset();
        m_wait = 0; m_req = 0; m_trap = 0; m_vld = 0; m_mip = 0;
        m_epc = '0; m_cause = '0; m_lat = '0;
    endtask

    task automatic step();
        bit     pend;
        longint span;
        pend  = timer_int_i & mstatus_mie_i & mie_mtie_i;
        m_vld = 0;
        if (m_req) begin
            if (int_ack_i) begin
                span   = cyc - arm_cyc + 1;
                m_lat  = (span > LAT_MAX) ? LAT_MAX : span;
                m_vld  = 1;
                m_req  = 0;
                m_trap = 1;
            end
        end else if (m_trap) begin
            if (mret_i) m_trap = 0;
        end else if (m_wait && !pend) begin
            m_wait = 0;
        end else if (pend) begin
            if (!m_wait) arm_cyc = cyc;
            if (commit_valid_i) begin
                m_wait  = 0;
                m_req   = 1;
                m_epc   = commit_npc_i;
                m_cause = MTI;
            end else begin
                m_wait = 1;
            end
        end
        m_mip = timer_int_i;
        cyc++;
        @(posedge clk);
        #1;
        chk("req",     {63'd0, int_req_o},     {63'd0, m_req});
        chk("mip",     {63'd0, mip_mtip_o},    {63'd0, m_mip});
        chk("lat_vld", {63'd0, int_lat_vld_o}, {63'd0, m_vld});
        chk("latency", 64'(int_latency_o),     m_lat);
        chk("epc",     int_epc_o,              m_epc);
        chk("cause",   int_cause_o,            m_cause);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic async_reset_mid();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req",   {63'd0, int_req_o},  64'd0);
        chk("arst_mip",   {63'd0, mip_mtip_o}, 64'd0);
        chk("arst_epc",   int_epc_o,           64'd0);
        chk("arst_cause", int_cause_o,         64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_req",   {63'd0, int_req_o},     64'd0);
        chk("rst_mip",   {63'd0, mip_mtip_o},    64'd0);
        chk("rst_vld",   {63'd0, int_lat_vld_o}, 64'd0);
        chk("rst_lat",   64'(int_latency_o),     64'd0);
        chk("rst_epc",   int_epc_o,              64'd0);
        chk("rst_cause", int_cause_o,            64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1/2: arm, three idle-retire cycles, commit, two REQ cycles with ack on the second.
        timer_int_i = 1; mstatus_mie_i = 1; mie_mtie_i = 1;
        step();
        steps(3);
        commit_valid_i = 1; commit_npc_i = 64'h8000_0010;
        step();
        commit_valid_i = 0; commit_npc_i = 64'hDEAD_BEEF;
        chk("t1_req",   {63'd0, int_req_o}, 64'd1);
        chk("t1_epc",   int_epc_o,          64'h8000_0010);
        chk("t1_cause", int_cause_o,        MTI);
        step();
        int_ack_i = 1;
        step();
        int_ack_i = 0;
        chk("t2_lat",  64'(int_latency_o),     64'd7);
        chk("t2_vld",  {63'd0, int_lat_vld_o}, 64'd1);
        commit_valid_i = 1;
        steps(5);
        chk("t2_blocked", {63'd0, int_req_o}, 64'd0);
        commit_valid_i = 0; mret_i = 1;
        step();
        mret_i = 0; commit_valid_i = 1; commit_npc_i = 64'h8000_0100;
        step();
        commit_valid_i = 0;
        chk("t2_rearm", {63'd0, int_req_o}, 64'd1);
        int_ack_i = 1; step(); int_ack_i = 0;
        mret_i = 1; step(); mret_i = 0;

        // 3: arm then clear MIE before any commit.
        step();
        mstatus_mie_i = 0; commit_valid_i = 1;
        steps(4);
        commit_valid_i = 0;
        chk("t3_noreq", {63'd0, int_req_o},     64'd0);
        chk("t3_mip",   {63'd0, mip_mtip_o},    64'd1);
        chk("t3_novld", {63'd0, int_lat_vld_o}, 64'd0);

        // 4: enter REQ, drop the timer; the request holds.
        mstatus_mie_i = 1; commit_valid_i = 1; commit_npc_i = 64'h1234_5678_9ABC_DEF0;
        step();
        commit_valid_i = 0; timer_int_i = 0; commit_npc_i = 64'h0;
        steps(3);
        chk("t4_req", {63'd0, int_req_o}, 64'd1);
        chk("t4_epc", int_epc_o,          64'h1234_5678_9ABC_DEF0);
        int_ack_i = 1; mret_i = 1; step(); int_ack_i = 0; mret_i = 0;
        mret_i = 1; step(); mret_i = 0;

        // 5: long ARMED wait saturates the latency counter.
        timer_int_i = 1;
        step();
        steps(70000);
        commit_valid_i = 1; step(); commit_valid_i = 0;
        int_ack_i = 1; step(); int_ack_i = 0;
        chk("t5_sat", 64'(int_latency_o), 64'hFFFF);
        mret_i = 1; step(); mret_i = 0;

        // 6: async reset while requesting, then normal re-arm.
        commit_valid_i = 1; commit_npc_i = 64'h8000_0200;
        step();
        async_reset_mid();
        commit_valid_i = 0;
        step();
        chk("t6_armed", {63'd0, int_req_o}, 64'd0);
        commit_valid_i = 1; commit_npc_i = 64'h8000_0300;
        step();
        commit_valid_i = 0;
        chk("t6_req", {63'd0, int_req_o}, 64'd1);
        int_ack_i = 1; step(); int_ack_i = 0;
        mret_i = 1; step(); mret_i = 0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            timer_int_i    = ($urandom_range(0, 9) < 7);
            mstatus_mie_i  = ($urandom_range(0, 9) < 9);
            mie_mtie_i     = ($urandom_range(0, 9) < 9);
            commit_valid_i = ($urandom_range(0, 1) == 1);
            commit_npc_i   = {$urandom, $urandom};
            int_ack_i      = ($urandom_range(0, 9) < 3);
            mret_i         = ($urandom_range(0, 9) < 2);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
